text_line_loader: RTL and testbench
===================================

// Module: text_line_loader
// PURPOSE
//  Upstream feeder for the text overlay stage: accepts an ASCII byte stream over a
//  valid/ready handshake and assembles it in a shadow line buffer. Commits the line
//  to the packed o_characters bus only on a frame boundary (i_vsync rising edge),
//  so the overlay never shows a half-written line. Runs in the pixel clock domain.
// PARAMETERS
//  COLUMNS   13     characters per line; o_characters width = COLUMNS*8
//  PAD_CHAR  8'h20  fill byte for unused columns and the reset image
// PORTS
//  i_clk         in   1          pixel clock; sole clock
//  i_rst         in   1          reset, asynchronous, active-high
//  i_data        in   8          ASCII byte
//  i_valid       in   1          i_data valid
//  i_last        in   1          with i_valid: final byte of message
//  o_ready       out  1          byte accepted on cycle with i_valid && o_ready
//  i_vsync       in   1          vsync level, synchronous to i_clk
//  o_characters  out  COLUMNS*8  committed line; column 0 in bits [COLUMNS*8-1 -: 8]
//  o_swap        out  1          1-cycle pulse when o_characters updates
//  o_pending     out  1          complete line waiting for frame boundary
//  o_overflow    out  1          sticky: bytes beyond COLUMNS were dropped
// BEHAVIOUR
//  - Reset (async): state IDLE, column ptr 0, shadow and o_characters = all PAD_CHAR;
//    o_ready/o_swap/o_pending/o_overflow = 0; vsync_q = 0. All outputs registered.
//  - o_ready: 0 in reset, 1 on first clock after release; next value = (next_state != PENDING).
//  - Column ptr width $clog2(COLUMNS+1); saturates at COLUMNS, never wraps.
//  - IDLE: on accept, shadow cleared to PAD_CHAR except col 0 = i_data; ptr=1; -> FILL,
//    or -> PENDING if i_last.
//  - FILL: on accept with ptr<COLUMNS, shadow[ptr]=i_data, ptr++. With ptr==COLUMNS,
//    byte discarded, o_overflow set. Accept with i_last -> PENDING (columns not written
//    keep PAD_CHAR); a discarded last byte still terminates.
//  - PENDING: o_ready=0, o_pending=1; i_valid ignored, nothing consumed.
//  - Frame edge = i_vsync && !vsync_q (vsync_q registered each clock). Edge seen in
//    PENDING: on that clock o_characters<=shadow, o_swap=1 next cycle only,
//    o_overflow cleared, o_pending=0, ptr=0, -> IDLE (o_ready=1 same cycle as o_swap).
//  - Edge in IDLE/FILL: no effect. Edge in the same cycle as the last-byte accept:
//    ignored; commit waits for the next edge.
//  - i_vsync high at reset release counts as an edge on first clock (vsync_q=0);
//    harmless since state is IDLE.
//  - Single-byte message (i_last on first byte) legal: col 0 = byte, rest PAD_CHAR.
//  - Reset mid-fill or mid-pending: partial/pending line lost, o_characters back to pads.
//  - Latency: last byte accept -> o_pending 1 cycle later; frame edge -> o_characters
//    and o_swap valid 1 cycle later.
// TESTING
//  1 Reset then release -> o_characters = 13x8'h20, o_ready 0 in reset, 1 one cycle
//    after; o_swap/o_pending/o_overflow 0.
//  2 Stream "Hello, world!" (13 bytes, i_last on '!'), then vsync rise -> o_ready 0
//    after '!', o_pending 1; one cycle after edge o_characters == "Hello, world!",
//    o_swap single pulse, o_ready 1.
//  3 Stream "Hi" (i_last on 'i') + edge -> o_characters == "Hi" followed by 11x8'h20.
//  4 Stream "Hello, world!!!" (15 bytes) -> o_overflow 1 after 14th byte; commit shows
//    "Hello, world!"; o_overflow 0 after swap.
//  5 i_last accept coincident with vsync rise -> no o_swap; swap on next rise only;
//    i_valid held high in PENDING consumes no bytes.
//  6 Assert i_rst after 5 bytes of message 2 with message 1 committed -> o_characters
//    all 8'h20 immediately (async); next full message commits cleanly.

Source files
------------

// File: rtl/text_line_loader.sv
// text_line_loader
//   Collects an ASCII byte stream into a shadow line buffer and publishes the
//   finished line on o_characters only at a frame boundary (rising i_vsync).
//   The overlay therefore never shows a half-written line.
//
// Ports
//   i_clk         pixel clock, sole clock
//   i_rst         asynchronous active-high reset
//   i_data        ASCII byte
//   i_valid       i_data valid
//   i_last        with i_valid: final byte of the message
//   o_ready       byte accepted on a cycle with i_valid && o_ready
//   i_vsync       vsync level, synchronous to i_clk
//   o_characters  committed line, column 0 in the top byte
//   o_swap        one-cycle pulse when o_characters updates
//   o_pending     complete line waiting for a frame boundary
//   o_overflow    sticky: bytes beyond COLUMNS were dropped
module text_line_loader #(
  parameter int         COLUMNS  = 13,
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_data,
  input  logic                 i_valid,
  input  logic                 i_last,
  output logic                 o_ready,
  input  logic                 i_vsync,
  output logic [COLUMNS*8-1:0] o_characters,
  output logic                 o_swap,
  output logic                 o_pending,
  output logic                 o_overflow
);

  localparam int PTR_W = $clog2(COLUMNS + 1);
  localparam int IDX_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PTR_W-1:0]     r_ptr;
  logic [7:0]           r_shadow [COLUMNS];
  logic [COLUMNS*8-1:0] r_characters;
  logic                 r_swap;
  logic                 r_pending;
  logic                 r_overflow;
  logic                 r_ready;
  logic                 r_vsync_q;

  logic                 w_accept;
  logic                 w_edge;
  logic                 w_start;
  logic                 w_store;
  logic                 w_ovf_set;
  logic                 w_commit;
  logic [IDX_W-1:0]     w_col;
  logic [COLUMNS*8-1:0] w_shadow_flat;

  assign w_accept = i_valid && r_ready;
  assign w_edge   = i_vsync && !r_vsync_q;
  assign w_col    = r_ptr[IDX_W-1:0];

  // Pack the shadow array so column 0 lands in the most significant byte.
  always_comb begin
    w_shadow_flat = '0;
    for (int c = 0; c < COLUMNS; c++) begin
      w_shadow_flat[(COLUMNS-1-c)*8 +: 8] = r_shadow[c];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_store     = 1'b0;
    w_ovf_set   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_start     = 1'b1;
          w_state_nxt = i_last ? ST_PENDING : ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_accept) begin
          // A full line drops the byte but still honours i_last.
          if (r_ptr < PTR_W'(COLUMNS)) begin
            w_store = 1'b1;
          end else begin
            w_ovf_set = 1'b1;
          end
          if (i_last) begin
            w_state_nxt = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        // Only reachable a cycle after the last byte, so an edge coincident
        // with that accept is seen in FILL and ignored.
        if (w_edge) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered datapath and status outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr        <= '0;
      for (int c = 0; c < COLUMNS; c++) begin
        r_shadow[c] <= PAD_CHAR;
      end
      r_characters <= {COLUMNS{PAD_CHAR}};
      r_swap       <= 1'b0;
      r_pending    <= 1'b0;
      r_overflow   <= 1'b0;
      r_ready      <= 1'b0;
      r_vsync_q    <= 1'b0;
    end else begin
      r_vsync_q <= i_vsync;
      r_ready   <= (w_state_nxt != ST_PENDING);
      r_pending <= (w_state_nxt == ST_PENDING);
      r_swap    <= w_commit;

      if (w_start) begin
        for (int c = 0; c < COLUMNS; c++) begin
          r_shadow[c] <= (c == 0) ? i_data : PAD_CHAR;
        end
        r_ptr <= PTR_W'(1);
      end else if (w_store) begin
        r_shadow[w_col] <= i_data;
        r_ptr           <= r_ptr + PTR_W'(1);
      end

      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_commit) begin
        r_overflow <= 1'b0;
      end

      if (w_commit) begin
        r_characters <= w_shadow_flat;
        r_ptr        <= '0;
      end
    end
  end

  assign o_ready      = r_ready;
  assign o_characters = r_characters;
  assign o_swap       = r_swap;
  assign o_pending    = r_pending;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_text_line_loader.sv
module tb_text_line_loader;

  localparam int COLS = 13;
  localparam int W    = COLS * 8;
  localparam logic [W-1:0] PADS = {COLS{8'h20}};

  logic         clk;
  logic         rst;
  logic [7:0]   data;
  logic         valid;
  logic         last;
  logic         vsync;
  logic         ready;
  logic [W-1:0] chars;
  logic         swap;
  logic         pending;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  text_line_loader #(.COLUMNS(COLS), .PAD_CHAR(8'h20)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (data),
    .i_valid     (valid),
    .i_last      (last),
    .o_ready     (ready),
    .i_vsync     (vsync),
    .o_characters(chars),
    .o_swap      (swap),
    .o_pending   (pending),
    .o_overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: a message is a queue of bytes; a line is its first
  // COLS bytes padded with spaces; a finished message waits for a vsync rise.
  logic [7:0]   m_msg[$];
  logic         m_pending = 1'b0;
  logic         m_ovf     = 1'b0;
  logic         m_swap    = 1'b0;
  logic         m_ready   = 1'b0;
  logic         m_vq      = 1'b0;
  logic [W-1:0] m_chars   = PADS;

  function automatic logic [W-1:0] line_of(input logic [7:0] q[$]);
    logic [W-1:0] r;
    r = PADS;
    for (int c = 0; c < COLS; c++) begin
      if (c < q.size()) r[(COLS-1-c)*8 +: 8] = q[c];
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_msg.delete();
      m_pending = 1'b0;
      m_ovf     = 1'b0;
      m_swap    = 1'b0;
      m_ready   = 1'b0;
      m_vq      = 1'b0;
      m_chars   = PADS;
    end else begin
      logic acc, edge_seen;
      acc       = valid && m_ready;
      edge_seen = vsync && !m_vq;
      m_vq      = vsync;
      m_swap    = 1'b0;
      if (m_pending) begin
        if (edge_seen) begin
          m_chars   = line_of(m_msg);
          m_swap    = 1'b1;
          m_ovf     = 1'b0;
          m_pending = 1'b0;
          m_msg.delete();
        end
      end else if (acc) begin
        if (m_msg.size() < COLS) m_msg.push_back(data);
        else m_ovf = 1'b1;
        if (last) m_pending = 1'b1;
      end
      m_ready = !m_pending;
    end
  end

  always @(negedge clk) begin
    chk("ready", W'(ready), W'(m_ready));
    chk("swap", W'(swap), W'(m_swap));
    chk("pending", W'(pending), W'(m_pending));
    chk("overflow", W'(overflow), W'(m_ovf));
    chk("characters", chars, m_chars);
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    logic acc;
    int   n;
    data  = d;
    last  = l;
    valid = 1'b1;
    n     = 0;
    do begin
      acc = ready;
      @(posedge clk);
      #2;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      errors++;
      $display("FAIL handshake: byte %h not accepted within 50 cycles", d);
    end
  endtask

  task automatic send_str(input string s, input logic with_last);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], with_last && (i == s.len() - 1));
    end
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    @(posedge clk);
    #2;
    vsync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    data  = 8'h00;
    valid = 1'b0;
    last  = 1'b0;
    vsync = 1'b0;

    // Test 1: reset image and first ready
    #1;
    chk("t1 chars in reset", chars, PADS);
    chk("t1 ready in reset", W'(ready), W'(0));
    idle(2);
    rst = 1'b0;
    chk("t1 ready after release", W'(ready), W'(0));
    idle(1);
    chk("t1 ready one cycle after", W'(ready), W'(1));
    chk("t1 pending", W'(pending), W'(0));
    chk("t1 overflow", W'(overflow), W'(0));

    // Test 2: full 13-character line
    send_str("Hello, world!", 1'b1);
    chk("t2 ready after last", W'(ready), W'(0));
    chk("t2 pending after last", W'(pending), W'(1));
    idle(3);
    chk("t2 chars before edge", chars, PADS);
    vsync_pulse();
    chk("t2 chars committed", chars, "Hello, world!");
    chk("t2 swap pulse", W'(swap), W'(1));
    chk("t2 ready with swap", W'(ready), W'(1));
    idle(1);
    chk("t2 swap drops", W'(swap), W'(0));

    // Test 3: short line padded
    send_str("Hi", 1'b1);
    idle(2);
    vsync_pulse();
    chk("t3 chars Hi", chars, {"Hi", {11{8'h20}}});

    // Test 4: overflow
    send_str("Hello, world!", 1'b0);
    chk("t4 no overflow at 13", W'(overflow), W'(0));
    send_byte("!", 1'b0);
    chk("t4 overflow at 14", W'(overflow), W'(1));
    send_byte("!", 1'b1);
    valid = 1'b0;
    last  = 1'b0;
    chk("t4 pending after dropped last", W'(pending), W'(1));
    idle(2);
    vsync_pulse();
    chk("t4 chars truncated", chars, "Hello, world!");
    chk("t4 overflow cleared", W'(overflow), W'(0));

    // Test 5: edge coincident with last byte, valid held while pending
    send_str("SyncEdg", 1'b0);
    vsync = 1'b1;
    send_byte("e", 1'b1);
    vsync = 1'b0;
    chk("t5 no swap on coincident edge", W'(swap), W'(0));
    chk("t5 pending", W'(pending), W'(1));
    data  = "Z";
    last  = 1'b1;
    valid = 1'b1;
    idle(4);
    chk("t5 still pending", W'(pending), W'(1));
    chk("t5 chars unchanged", chars, "Hello, world!");
    vsync_pulse();
    chk("t5 chars on next edge", chars, {"SyncEdge", {5{8'h20}}});
    chk("t5 swap on next edge", W'(swap), W'(1));
    idle(1);
    valid = 1'b0;
    last  = 1'b0;
    chk("t5 held byte taken", W'(pending), W'(1));
    idle(1);
    vsync_pulse();
    chk("t5 held byte line", chars, {"Z", {12{8'h20}}});

    // Test 6: reset mid-fill
    send_str("ABC", 1'b1);
    vsync_pulse();
    chk("t6 msg1 committed", chars, {"ABC", {10{8'h20}}});
    send_str("DEFGH", 1'b0);
    rst = 1'b1;
    #1;
    chk("t6 chars async reset", chars, PADS);
    chk("t6 ready in reset", W'(ready), W'(0));
    chk("t6 pending in reset", W'(pending), W'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(1);
    send_str("Clean line 13", 1'b1);
    idle(1);
    vsync_pulse();
    chk("t6 clean commit", chars, "Clean line 13");
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
